memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, a word-addressed data memory and the MEM/WB pipeline register.
- Produces ALUOutM, which execute forwards on ForwardAE/BE = 2'b10.
- Produces ResultW and WriteRegW/RegWriteW for register-file writeback; ResultW is also forwarded into execute on 2'b01.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/data_memory.sv | 29 ++
 rtl/memory_stage.sv | 88 ++++++++
 tb/tb_memory_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared pipeline widths, forwarding-select codes and payload types.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic                  memwrite;
    logic [WORD_W-1:0]     aluout;
    logic [WORD_W-1:0]     writedata;
    logic [REG_ADDR_W-1:0] writereg;
  } ex_mem_t;

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [WORD_W-1:0]     readdata;
    logic [WORD_W-1:0]     aluout;
    logic [REG_ADDR_W-1:0] writereg;
  } mem_wb_t;
endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// +----------------------------------------------------------------------+
// | data_memory                                                          |
// | Word-addressed data RAM: synchronous write, asynchronous read.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module data_memory #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wd;
    end
  end

  assign rd = r_mem[addr];
endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// +----------------------------------------------------------------------+
// | memory_stage                                                         |
// | EX/MEM register, data memory access and MEM/WB register.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  MemWriteE,
  input  logic [DATA_W-1:0]     ALUOutE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  AlignErrM,
  output logic [DATA_W-1:0]     ResultW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  RegWriteW
);
  ex_mem_t           r_exmem;
  mem_wb_t           r_memwb;
  logic [DATA_W-1:0] w_readdata;
  logic              w_alignerr;
  logic              w_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exmem <= '0;
    end else begin
      r_exmem <= '{regwrite:  RegWriteE,
                   memtoreg:  MemtoRegE,
                   memwrite:  MemWriteE,
                   aluout:    ALUOutE,
                   writedata: WriteDataE,
                   writereg:  WriteRegE};
    end
  end

  assign w_alignerr = (r_exmem.memwrite | r_exmem.memtoreg) & (r_exmem.aluout[1:0] != 2'b00);
  // A store caught by reset at its MEM edge must not land in memory.
  assign w_we       = r_exmem.memwrite & ~w_alignerr & ~rst;

  data_memory #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_dmem (
    .clk (clk),
    .we  (w_we),
    .addr(r_exmem.aluout[DEPTH_LOG2+1:2]),
    .wd  (r_exmem.writedata),
    .rd  (w_readdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memwb <= '0;
    end else begin
      r_memwb <= '{regwrite: r_exmem.regwrite & ~(r_exmem.memtoreg & w_alignerr),
                   memtoreg: r_exmem.memtoreg,
                   readdata: w_readdata,
                   aluout:   r_exmem.aluout,
                   writereg: r_exmem.writereg};
    end
  end

  assign ALUOutM   = r_exmem.aluout;
  assign WriteRegM = r_exmem.writereg;
  assign RegWriteM = r_exmem.regwrite;
  assign MemtoRegM = r_exmem.memtoreg;
  assign AlignErrM = w_alignerr;

  assign ResultW   = r_memwb.memtoreg ? r_memwb.readdata : r_memwb.aluout;
  assign WriteRegW = r_memwb.writereg;
  assign RegWriteW = r_memwb.regwrite;
endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// +----------------------------------------------------------------------+
// | tb_memory_stage                                                      |
// | Directed stimulus with a cycle-level reference model of memory_stage.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_memory_stage;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUOutM, ResultW;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, MemtoRegM, AlignErrM, RegWriteW;

  memory_stage #(.DEPTH_LOG2(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .AlignErrM(AlignErrM), .ResultW(ResultW),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction in MEM, instruction in WB, and memory image.
  typedef struct packed {
    logic        rw, mr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
  } ins_t;

  ins_t        m_mem;
  logic        wb_rw, wb_mr, wb_rdk;
  logic [31:0] wb_alu, wb_rd;
  logic [4:0]  wb_wr;
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  bit          m_init = 1'b0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit misaligned(input ins_t i);
    return (i.mw || i.mr) && (i.alu % 4 != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mem  <= '0;
      wb_rw  <= 1'b0; wb_mr <= 1'b0; wb_rdk <= 1'b0;
      wb_alu <= '0;   wb_rd <= '0;   wb_wr  <= '0;
      m_init <= 1'b1;
    end else begin
      wb_rw  <= m_mem.rw && !(m_mem.mr && misaligned(m_mem));
      wb_mr  <= m_mem.mr;
      wb_alu <= m_mem.alu;
      wb_wr  <= m_mem.wr;
      wb_rd  <= mm[word_of(m_mem.alu)];
      wb_rdk <= mk[word_of(m_mem.alu)];
      if (m_mem.mw && !misaligned(m_mem)) begin
        mm[word_of(m_mem.alu)] <= m_mem.wd;
        mk[word_of(m_mem.alu)] <= 1'b1;
      end
      m_mem <= '{rw: RegWriteE, mr: MemtoRegE, mw: MemWriteE,
                 alu: ALUOutE, wd: WriteDataE, wr: WriteRegE};
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ALUOutM",   ALUOutM,          m_mem.alu);
      chk("WriteRegM", {27'd0, WriteRegM}, {27'd0, m_mem.wr});
      chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, m_mem.rw});
      chk("MemtoRegM", {31'd0, MemtoRegM}, {31'd0, m_mem.mr});
      chk("AlignErrM", {31'd0, AlignErrM}, {31'd0, misaligned(m_mem)});
      chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, wb_rw});
      chk("WriteRegW", {27'd0, WriteRegW}, {27'd0, wb_wr});
      if (!wb_mr || wb_rdk)
        chk("ResultW", ResultW, wb_mr ? wb_rd : wb_alu);
    end
  end

  task automatic issue(input bit rw, input bit mr, input bit mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    @(posedge clk); #1;
    RegWriteE = rw; MemtoRegE = mr; MemWriteE = mw;
    ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
  endtask

  task automatic nop();
    issue(0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    RegWriteE = 1'b1; MemtoRegE = 1'b0; MemWriteE = 1'b0;
    ALUOutE = 32'hDEADBEEF; WriteDataE = 32'h0; WriteRegE = 5'd0;

    // Reset held for two edges with live inputs.
    @(posedge clk);
    @(negedge clk);
    chk("rst_aluoutm",   ALUOutM, 32'h0);
    chk("rst_regwritem", {31'd0, RegWriteM}, 32'h0);
    chk("rst_resultw",   ResultW, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_aluoutm", ALUOutM, 32'h0);
    @(negedge clk);
    chk("post_rst_aluoutm", ALUOutM, 32'hDEADBEEF);

    // ALU pass-through.
    issue(1, 0, 0, 32'h1234, 32'h0, 5'd8);
    nop(); @(negedge clk);
    chk("alu_m", ALUOutM, 32'h1234);
    nop(); @(negedge clk);
    chk("alu_resultw",   ResultW, 32'h1234);
    chk("alu_writeregw", {27'd0, WriteRegW}, 32'd8);
    chk("alu_regwritew", {31'd0, RegWriteW}, 32'd1);

    // $0 destination is carried unchanged.
    issue(1, 0, 0, 32'h55, 32'h0, 5'd0);
    issue(1, 0, 0, 32'hFFFF_FFFC, 32'h0, 5'd31);

    // Store then load back-to-back to the same word.
    issue(0, 0, 1, 32'h10, 32'hCAFEF00D, 5'd0);
    issue(1, 1, 0, 32'h10, 32'h0, 5'd9);
    nop(); @(negedge clk);
    nop(); @(negedge clk);
    chk("sl_resultw",   ResultW, 32'hCAFEF00D);
    chk("sl_regwritew", {31'd0, RegWriteW}, 32'd1);
    chk("sl_writeregw", {27'd0, WriteRegW}, 32'd9);

    // Aliasing: 0x100 wraps onto word 0.
    issue(0, 0, 1, 32'h100, 32'hA5A5A5A5, 5'd0);
    issue(1, 1, 0, 32'h0, 32'h0, 5'd3);
    nop(); @(negedge clk);
    nop(); @(negedge clk);
    chk("alias_resultw", ResultW, 32'hA5A5A5A5);

    // Misalignment: neither the store nor the load may take effect.
    issue(0, 0, 1, 32'h20, 32'h55555555, 5'd0);
    issue(0, 0, 1, 32'h22, 32'h1, 5'd0);
    nop(); @(negedge clk);
    chk("mis_store_alignerr", {31'd0, AlignErrM}, 32'd1);
    issue(1, 1, 0, 32'h22, 32'h0, 5'd10);
    nop(); @(negedge clk);
    chk("mis_load_alignerr", {31'd0, AlignErrM}, 32'd1);
    nop(); @(negedge clk);
    chk("mis_load_regwritew", {31'd0, RegWriteW}, 32'd0);
    issue(1, 1, 0, 32'h20, 32'h0, 5'd11);
    nop(); @(negedge clk);
    nop(); @(negedge clk);
    chk("mis_word_unchanged", ResultW, 32'h55555555);

    // Reset arriving while a store sits in MEM.
    issue(0, 0, 1, 32'h4, 32'h11, 5'd0);
    issue(0, 0, 1, 32'h4, 32'h77, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
    ALUOutE = 32'h0; WriteDataE = 32'h0; WriteRegE = 5'd0;
    @(posedge clk); #1 rst = 1'b0;
    issue(1, 1, 0, 32'h4, 32'h0, 5'd12);
    nop(); @(negedge clk);
    nop(); @(negedge clk);
    chk("rst_store_suppressed", ResultW, 32'h11);

    nop(); nop();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
